mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-ported backing memory between the fetch stage (I-side, reads
//   only) and the MEM stage (D-side, reads and byte/word writes). Sequences each
//   access over a fixed multi-cycle latency and returns a one-cycle ready pulse;
//   the pipeline derives if_stall / mem_stall from it.
// PARAMETERS
//   MEM_LATENCY  5   cycles from grant to ready pulse (legal range 2..15)
//   ADDR_W       16  address width
//   DATA_W       16  data width (two byte lanes)
// PORTS
//   clk          in   1       system clock
//   reset        in   1       synchronous, active-high reset
//   if_req       in   1       fetch read request, held until if_ready
//   if_addr      in   ADDR_W  fetch address
//   if_abort     in   1       fetch redirect; suppresses pending I-side response
//   if_ready     out  1       one-cycle pulse: if_rdata valid
//   if_rdata     out  DATA_W  fetched word
//   mem_req      in   1       data request, held until mem_ready
//   mem_we       in   1       1 = write, 0 = read
//   mem_wmask    in   2       byte-lane write enables ([0] low byte, [1] high)
//   mem_addr     in   ADDR_W  data address
//   mem_wdata    in   DATA_W  write data
//   mem_ready    out  1       one-cycle pulse: access complete, mem_rdata valid on reads
//   mem_rdata    out  DATA_W  read data
//   bmem_addr    out  ADDR_W  backing memory address
//   bmem_we      out  2       backing memory byte write strobes
//   bmem_wdata   out  DATA_W  backing memory write data
//   bmem_rdata   in   DATA_W  backing memory read data (synchronous, 1-cycle)
// BEHAVIOUR
//   - States: IDLE, ACCESS_I, ACCESS_D. Latency counter, 4 bits, loaded on grant.
//   - Reset: state IDLE, counter 0, all outputs 0, latched addr/data/mask 0.
//   - Arbitration in IDLE only, cycle G: mem_req wins over if_req (older instr).
//     No preemption: an in-flight access always runs to completion.
//   - On grant latch addr, we, wmask, wdata; requester inputs ignored until ready.
//   - bmem_addr = latched addr, stable from G+1 through G+MEM_LATENCY-1.
//   - Write: bmem_we = latched wmask for exactly one cycle, G+MEM_LATENCY-1;
//     0 in all other cycles. wmask==0 write still completes, no strobe.
//   - Read: bmem_rdata captured at end of G+MEM_LATENCY-1 into rdata register.
//   - Ready pulse in cycle G+MEM_LATENCY; *_rdata valid that cycle and holds
//     until next capture. State returns to IDLE the following cycle.
//   - Requester holding req in the cycle after ready = new request;
//     throughput one access per MEM_LATENCY+1 cycles.
//   - Both reqs in IDLE: D granted; I granted next IDLE cycle if still asserted.
//   - if_abort during ACCESS_I or in IDLE with grant to I: access completes
//     on schedule, if_ready suppressed, if_rdata not updated. Abort flag cleared
//     when state leaves ACCESS_I. if_abort has no effect on D-side.
//   - if_ready and mem_ready never high in the same cycle.
//   - Reset mid-access: abort immediately, no write strobe, no ready pulse.
// TESTING
//   - Reset then idle: all outputs 0, bmem_we==0 for 20 cycles.
//   - if_req, addr 0x3000, mem holds 0x1234, LATENCY 5: if_ready in G+5 only, if_rdata 0x1234.
//   - mem_req write addr 0x4001, wmask 2'b10, wdata 0xAB00: bmem_we 2'b10 in G+4 only; mem_ready G+5.
//   - if_req & mem_req same cycle: D completes at G+5, I granted G+6, if_ready G+11.
//   - if_abort pulse at G+2 of fetch: no if_ready; next fetch 0x3002 returns normally.
//   - reset at G+3 of a D write: no bmem_we, no mem_ready, state IDLE next cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the pipeline-facing request/response signals of both requesters
//   (I-side fetch, D-side MEM stage) and the backing-memory port of the
//   single-ported memory arbiter.
//
//   I-side  : if_req, if_addr, if_abort  -> arbiter ; if_ready, if_rdata <-
//   D-side  : mem_req, mem_we, mem_wmask, mem_addr, mem_wdata -> arbiter ;
//             mem_ready, mem_rdata <-
//   Backing : bmem_addr, bmem_we, bmem_wdata <- arbiter ; bmem_rdata ->
//
//   Modports:
//     slave  - the arbiter's view (consumes requests, drives the memory port)
//     master - the surrounding system's view (pipeline plus backing memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // I-side (fetch, read only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_abort;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  // D-side (MEM stage, reads and byte/word writes)
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_wmask;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Backing memory port (synchronous read, one-cycle latency)
  logic [ADDR_W-1:0] bmem_addr;
  logic [1:0]        bmem_we;
  logic [DATA_W-1:0] bmem_wdata;
  logic [DATA_W-1:0] bmem_rdata;

  modport slave (
    input  if_req, if_addr, if_abort,
    output if_ready, if_rdata,
    input  mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    output bmem_addr, bmem_we, bmem_wdata,
    input  bmem_rdata
  );

  modport master (
    output if_req, if_addr, if_abort,
    input  if_ready, if_rdata,
    output mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    input  bmem_addr, bmem_we, bmem_wdata,
    output bmem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported backing memory between the fetch stage (I-side,
//   reads only) and the MEM stage (D-side, reads and byte-lane writes). Each
//   granted access occupies the memory for a fixed MEM_LATENCY cycles and ends
//   with a one-cycle ready pulse to the requester that owns it.
//
//   Ports:
//     clk    - system clock
//     reset  - synchronous, active-high reset; aborts any access in flight
//     bus    - mem_port_arbiter_if.slave (requests, responses, memory port)
//
//   Timing, with G the IDLE cycle in which the grant is made:
//     G+1 .. G+L-1 : bmem_addr holds the latched address
//     G+L-1        : write strobe (writes) / read data captured (reads)
//     G+L          : ready pulse, rdata valid
//     G+L+1        : back in IDLE, may grant again
//   MEM_LATENCY must lie in 2..15 (the counter is 4 bits wide).
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 5,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS_I = 2'd1,
    S_ACCESS_D = 2'd2
  } state_e;

  // Counter value seen in the cycle G+k is k; it is 0 while idle.
  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY);
  localparam logic [3:0] CAP_CNT  = 4'(MEM_LATENCY - 1);

  state_e            state_q,     state_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              we_q,        we_d;
  logic [1:0]        wmask_q,     wmask_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              abort_q,     abort_d;
  logic [DATA_W-1:0] rbuf_q,      rbuf_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic capture_cyc;
  logic last_cyc;
  logic if_ready_w;
  logic mem_ready_w;

  assign capture_cyc = (cnt_q == CAP_CNT);
  assign last_cyc    = (cnt_q == LAST_CNT);

  // Ready pulses and the strobe are gated by reset so an access cut short by
  // reset shows neither, even in the cycle reset is first seen. A redirect
  // arriving in the ready cycle itself still suppresses the I-side pulse.
  assign if_ready_w  = ~reset & (state_q == S_ACCESS_I) & last_cyc &
                       ~abort_q & ~bus.if_abort;
  assign mem_ready_w = ~reset & (state_q == S_ACCESS_D) & last_cyc;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    abort_d     = abort_q;
    rbuf_d      = rbuf_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        // D-side wins: the MEM-stage instruction is older than the fetch.
        if (bus.mem_req) begin
          state_d = S_ACCESS_D;
          cnt_d   = 4'd1;
          addr_d  = bus.mem_addr;
          we_d    = bus.mem_we;
          wmask_d = bus.mem_wmask;
          wdata_d = bus.mem_wdata;
          abort_d = 1'b0;
        end else if (bus.if_req) begin
          state_d = S_ACCESS_I;
          cnt_d   = 4'd1;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          wmask_d = 2'b00;
          wdata_d = '0;
          abort_d = bus.if_abort;   // redirect in the grant cycle counts too
        end
      end

      S_ACCESS_I: begin
        if (bus.if_abort) abort_d = 1'b1;
        if (capture_cyc)  rbuf_d  = bus.bmem_rdata;
        if (last_cyc) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          abort_d = 1'b0;
          // if_rdata only moves on a delivered fetch; aborted ones leave it.
          if (if_ready_w) if_rdata_d = rbuf_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_ACCESS_D: begin
        if (capture_cyc && !we_q) rbuf_d = bus.bmem_rdata;
        if (last_cyc) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          if (!we_q) mem_rdata_d = rbuf_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wmask_q     <= 2'b00;
      wdata_q     <= '0;
      abort_q     <= 1'b0;
      rbuf_q      <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      abort_q     <= abort_d;
      rbuf_q      <= rbuf_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // rdata is forwarded from the capture buffer during the ready cycle and held
  // in a per-side register afterwards, so it is valid in the pulse cycle.
  assign bus.if_ready   = if_ready_w;
  assign bus.if_rdata   = if_ready_w ? rbuf_q : if_rdata_q;
  assign bus.mem_ready  = mem_ready_w;
  assign bus.mem_rdata  = (mem_ready_w && !we_q) ? rbuf_q : mem_rdata_q;

  assign bus.bmem_addr  = addr_q;
  assign bus.bmem_wdata = wdata_q;
  assign bus.bmem_we    = (~reset && state_q == S_ACCESS_D && we_q && capture_cyc)
                          ? wmask_q : 2'b00;

endmodule
